// File: rtl/audio_pkg.sv
// Shared types and frame geometry for the I2S transmit path.
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int DATA_BITS  = 16;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;

  typedef enum logic {
    IDLE,
    RUN
  } tx_state_t;

  // Slots 1..DATA_BITS carry sample bits; slot 0 is the I2S one-bit delay.
  function automatic logic slot_has_data(input logic [4:0] slot);
    return (slot >= 5'd1) && (slot <= 5'(DATA_BITS));
  endfunction

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock divider: BCLK toggles every BCLK_HALF cycles; fall strobes in the
// cycle whose closing edge takes BCLK from 1 to 0.
module bclk_gen #(
  parameter int BCLK_HALF = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic BCLK,
  output logic fall
);

  localparam int CW = $clog2(BCLK_HALF);
  localparam logic [CW-1:0] LAST = CW'(BCLK_HALF - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  always_comb begin
    wrap      = (div_cnt_q == LAST);
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d    = wrap ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign BCLK = bclk_q;
  assign fall = wrap & bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Mono-to-stereo I2S transmitter with a one-entry holding register; outputs
// change only on BCLK falling edges, so they are stable at every rising edge.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_HALF = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [DATA_BITS-1:0] Data_in,
  input  logic                 Data_valid,
  output logic                 Data_ready,
  output logic                 BCLK,
  output logic                 LRCLK,
  output logic                 DACDAT,
  output logic                 Underrun
);

  logic fall;

  bclk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_bclk_gen (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .BCLK    (BCLK),
    .fall    (fall)
  );

  sample_t   hold_q, hold_d;
  logic      hold_full_q, hold_full_d;
  sample_t   sample_q, sample_d;
  sample_t   shift_q, shift_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  tx_state_t state_q, state_d;
  logic      dacdat_q, dacdat_d;
  logic      underrun_q, underrun_d;

  logic       accept;
  logic       frame_load;
  logic [5:0] bit_cnt_nxt;

  assign accept     = Data_valid & ~hold_full_q;
  assign frame_load = fall & (bit_cnt_q == 6'(FRAME_BITS - 1));

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sample_d    = sample_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    state_d     = state_q;
    dacdat_d    = dacdat_q;
    underrun_d  = underrun_q;
    bit_cnt_nxt = bit_cnt_q + 6'd1;

    if (fall) begin
      bit_cnt_d = bit_cnt_nxt;
      dacdat_d  = 1'b0;
      if (frame_load) begin
        // An empty holding register means the previous sample is replayed.
        if (hold_full_q) begin
          sample_d    = hold_q;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = RUN;
        end else begin
          shift_d = sample_q;
          if (state_q == RUN) begin
            underrun_d = 1'b1;
          end
        end
      end else if (bit_cnt_nxt == 6'(SLOT_BITS)) begin
        shift_d = sample_q;
      end else if (slot_has_data(bit_cnt_nxt[4:0])) begin
        dacdat_d = (state_q == RUN) & shift_q[DATA_BITS-1];
        shift_d  = {shift_q[DATA_BITS-2:0], 1'b0};
      end
    end

    // A sample accepted in the load cycle is held for the following frame.
    if (accept) begin
      hold_d      = Data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sample_q    <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      state_q     <= IDLE;
      dacdat_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sample_q    <= sample_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      state_q     <= state_d;
      dacdat_q    <= dacdat_d;
      underrun_q  <= underrun_d;
    end
  end

  assign Data_ready = ~hold_full_q;
  assign LRCLK      = bit_cnt_q[5];
  assign DACDAT     = dacdat_q;
  assign Underrun   = underrun_q;

endmodule
